iir_decim: RTL
==============

IIR_DECIM -- requirements
Module: iir_decim

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width of the IIR output z and of the decimated output.
REQ-002 SHALL have parameter MAX_LOG2D, default 4, meaning the largest decimation exponent (maximum D = 16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: global advance qualifier, matching the upstream iir enable.
REQ-006 SHALL have port in_valid, input, 1 bit: z_in carries a new sample this cycle.
REQ-007 SHALL have port z_in, input, DATA_W bits: signed two's-complement sample from the iir z output.
REQ-008 SHALL have port dec_log2, input, 3 bits: decimation exponent k, where D = 2^k.
REQ-009 SHALL have port out_data, output, DATA_W bits: signed decimated sample at the FIFO head.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid and out_ready are both high.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag indicating a result was dropped.
REQ-013 SHALL have port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-014 SHALL accept a sample only on a cycle with enable=1 and in_valid=1; on all other cycles the accumulator and counter hold.
REQ-015 SHALL latch k from dec_log2 when the first sample of a block is accepted (count=0); values above MAX_LOG2D clamp to MAX_LOG2D; changes mid-block SHALL be ignored.
REQ-016 SHALL use an accumulator of DATA_W+MAX_LOG2D bits, signed, loaded with sext(z_in) on the first sample and accumulating on each later sample.
REQ-017 SHALL compute the result at the D-th accepted sample as (acc_final + 2^(k-1)) >>> k with an arithmetic shift; when k=0 the result SHALL be z_in unchanged. No saturation is required, because the range cannot overflow.
REQ-018 SHALL push the result into the output FIFO on the same edge that accepts the D-th sample, so out_valid rises in the following cycle (latency 1), and SHALL reset count to 0 on that edge.
REQ-019 SHALL implement a 2-entry output FIFO in first-word-fall-through form; out_valid is high when the FIFO is not empty, and the FIFO is independent of enable.
REQ-020 SHALL perform both operations on a cycle with a simultaneous push and pop, including when full; pop on empty SHALL have no effect.
REQ-021 SHALL drop the result and set overrun when a push occurs with the FIFO full and no pop in that cycle.
REQ-022 SHALL clear overrun on overrun_clr, except that a set in the same cycle wins.
REQ-023 SHALL use a count register of MAX_LOG2D bits that wraps to 0 after D samples.

Reset
REQ-024 SHALL, while reset is high, force acc=0, count=0, latched k=0, FIFO empty, out_valid=0, out_data=0 and overrun=0, regardless of enable.
REQ-025 SHALL discard any partial block on a mid-block reset; the first accepted sample after reset SHALL start a new block.

Structure
REQ-026 SHALL take DATA_W, MAX_LOG2D and ACC_W=DATA_W+MAX_LOG2D from the shared package iir_pkg, which the iir block also uses.
REQ-027 SHALL implement the FIFO as the sub-module iir_decim_fifo (2 entries, push/pop/full/empty), and the rounding logic SHALL stay inline.

Verification
REQ-028 SHALL verify: k=2, samples 1,2,3,4 with out_ready=1 -> out_data=3, with out_valid high for one cycle, starting 1 cycle after the 4th sample.
REQ-029 SHALL verify: k=1, samples -1,-2 -> out_data=-1; k=0, sample -5 -> out_data=-5 on the next cycle.
REQ-030 SHALL verify: k=4, 16x(-128) -> -128, then 16x127 -> 127, with no wrap.
REQ-031 SHALL verify: k=0, out_ready=0, samples 1,2,3 -> 3 dropped and overrun=1; then out_ready=1 -> outputs 1 then 2; overrun_clr -> overrun=0.
REQ-032 SHALL verify: k=2, two samples, reset for 1 cycle, then 4x4 -> exactly one output of 4, with no residue from before reset.
REQ-033 SHALL verify: k=2 with enable toggling low between samples 2 and 3, and dec_log2 changed to 0 mid-block -> the block still averages 4 samples.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared sizing for the iir datapath and its decimator back-end.
package iir_pkg;
  localparam int DATA_W    = 8;
  localparam int MAX_LOG2D = 4;
  localparam int ACC_W     = DATA_W + MAX_LOG2D;

  // Clamp a requested decimation exponent to the supported maximum.
  function automatic logic [2:0] clamp_k(input logic [2:0] k, input int unsigned maxk);
    return (32'(k) > maxk) ? 3'(maxk) : k;
  endfunction
endpackage

// File: rtl/iir_decim_fifo.sv
// Two-entry first-word-fall-through FIFO; head word is always visible on rdata_o.
module iir_decim_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign rdata_o = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/iir_decim.sv
// Block-average decimator: sums 2^k accepted samples, rounds half-up, pushes one result.
module iir_decim #(
  parameter int DATA_W    = iir_pkg::DATA_W,
  parameter int MAX_LOG2D = iir_pkg::MAX_LOG2D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] z_in,
  input  logic [2:0]        dec_log2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              overrun_clr
);
  import iir_pkg::*;

  localparam int ACC_W = DATA_W + MAX_LOG2D;

  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum, bias, rnd, shifted;
  logic [MAX_LOG2D-1:0]      cnt_q, cnt_d;
  logic [2:0]                k_q, k_d, k_eff;
  logic [MAX_LOG2D:0]        d_m1;
  logic                      accept, first, last;
  logic                      ovr_q, ovr_d;
  logic                      fifo_full, fifo_empty, push, pop;
  logic [DATA_W-1:0]         result;

  assign accept = enable & in_valid;
  assign first  = (cnt_q == '0);

  // The exponent is captured on the first sample; later dec_log2 changes are ignored.
  assign k_eff   = first ? clamp_k(dec_log2, MAX_LOG2D) : k_q;
  assign d_m1    = (MAX_LOG2D+1)'((32'd1 << k_eff) - 32'd1);
  assign last    = accept && ({1'b0, cnt_q} == d_m1);

  assign acc_sum = first ? ACC_W'($signed(z_in)) : acc_q + ACC_W'($signed(z_in));
  assign bias    = (k_eff == 3'd0) ? '0 : (ACC_W'(1) << (k_eff - 3'd1));
  assign rnd     = acc_sum + bias;
  assign shifted = rnd >>> k_eff;
  assign result  = shifted[DATA_W-1:0];

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    k_d   = k_q;
    if (accept) begin
      acc_d = acc_sum;
      k_d   = k_eff;
      cnt_d = last ? '0 : cnt_q + MAX_LOG2D'(1);
    end
  end

  assign push = last;
  assign pop  = out_ready & ~fifo_empty;

  // Drop-on-full sets the sticky flag; a same-cycle set beats the clear.
  always_comb begin
    ovr_d = ovr_q;
    if (overrun_clr)                ovr_d = 1'b0;
    if (push & fifo_full & ~pop)    ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      k_q   <= '0;
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      k_q   <= k_d;
      ovr_q <= ovr_d;
    end
  end

  iir_decim_fifo #(.W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (result),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign overrun   = ovr_q;
endmodule
